// File: rtl/bin_line_window.sv
// Binarizes an RGB pixel stream and presents a WIN_H-tall column of binary pixels per output
// pixel, built from WIN_H-1 circular line memories. Fixed 2-clock latency from pixel to window.
module bin_line_window #(
    parameter int unsigned H_ACT = 1280,
    parameter int unsigned WIN_H = 5,
    parameter logic [7:0]  R_MIN = 8'd160,
    parameter logic [7:0]  G_MAX = 8'd90,
    parameter logic [7:0]  B_MAX = 8'd90
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [WIN_H-1:0] window
);

    localparam int unsigned NMEM = WIN_H - 1;
    localparam int unsigned PW   = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam int unsigned CW   = $clog2(H_ACT + 1);
    localparam int unsigned AW   = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int unsigned LW   = $clog2(WIN_H);

    // Column counter and line bookkeeping
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [LW-1:0] lines_q, lines_d;

    // Stage 1: binarized pixel plus its memory address
    logic          bin1_q, bin1_d;
    logic          valid1_q, valid1_d;
    logic [AW-1:0] addr1_q, addr1_d;
    logic          hs1_q, vs1_q, de1_q;

    // Stage 2: output registers
    logic             hs2_q, vs2_q, de2_q;
    logic [WIN_H-1:0] window_q, window_d;

    logic [H_ACT-1:0] line_mem [NMEM];

    logic in_range;
    logic bin;
    logic de_fall;

    always_comb begin
        in_range = (col_q < CW'(H_ACT));
        bin      = (r >= R_MIN) && (g <= G_MAX) && (b <= B_MAX);
        de_fall  = de1_q && !de;

        col_d = col_q;
        if (vsync || !de) begin
            col_d = '0;
        end else if (col_q != CW'(H_ACT)) begin
            col_d = col_q + 1'b1;
        end

        bin1_d   = de && bin;
        valid1_d = de && in_range;
        addr1_d  = in_range ? col_q[AW-1:0] : '0;

        wp_d    = wp_q;
        lines_d = lines_q;
        if (vsync) begin
            wp_d    = '0;
            lines_d = '0;
        end else if (de_fall) begin
            wp_d = (wp_q == PW'(NMEM - 1)) ? '0 : wp_q + 1'b1;
            if (lines_q != LW'(WIN_H - 1)) begin
                lines_d = lines_q + 1'b1;
            end
        end
    end

    // window[k] comes from the memory written k lines ago; k = NMEM lands on wp itself and
    // relies on the read returning the content before this cycle's write.
    always_comb begin
        int unsigned s;
        s        = 0;
        window_d = '0;
        if (valid1_q) begin
            window_d[0] = bin1_q;
            for (int unsigned k = 1; k < WIN_H; k++) begin
                s = 32'(wp_q) + NMEM - k;
                if (s >= NMEM) begin
                    s = s - NMEM;
                end
                if (k <= 32'(lines_q)) begin
                    window_d[k] = line_mem[s[PW-1:0]][addr1_q];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q    <= '0;
            wp_q     <= '0;
            lines_q  <= '0;
            bin1_q   <= 1'b0;
            valid1_q <= 1'b0;
            addr1_q  <= '0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            de1_q    <= 1'b0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            de2_q    <= 1'b0;
            window_q <= '0;
        end else begin
            col_q    <= col_d;
            wp_q     <= wp_d;
            lines_q  <= lines_d;
            bin1_q   <= bin1_d;
            valid1_q <= valid1_d;
            addr1_q  <= addr1_d;
            hs1_q    <= hsync;
            vs1_q    <= vsync;
            de1_q    <= de;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            de2_q    <= de1_q;
            window_q <= window_d;
        end
    end

    // Contents are never reset; stale bits are masked by lines_q.
    always_ff @(posedge clk) begin
        if (de1_q && valid1_q) begin
            line_mem[wp_q][addr1_q] <= bin1_q;
        end
    end

    assign o_hsync = hs2_q;
    assign o_vsync = vs2_q;
    assign o_de    = de2_q;
    assign window  = window_q;

endmodule

// File: tb/tb_bin_line_window.sv
// Directed bench for bin_line_window: every output cycle is checked against a hand-derived
// expectation queued two clocks earlier.
module tb_bin_line_window;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       de = 1'b0;
    logic [7:0] r = 8'd0;
    logic [7:0] g = 8'd0;
    logic [7:0] b = 8'd0;
    logic       o_hsync, o_vsync, o_de;
    logic [4:0] window;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_pipe = 8'h00;
    logic       in_rst = 1'b1;

    always #5 clk = ~clk;

    bin_line_window dut (
        .clk    (clk),
        .rstn   (rstn),
        .hsync  (hsync),
        .vsync  (vsync),
        .de     (de),
        .r      (r),
        .g      (g),
        .b      (b),
        .o_hsync(o_hsync),
        .o_vsync(o_vsync),
        .o_de   (o_de),
        .window (window)
    );

    // Apply one input cycle; check outputs for the input applied one step earlier.
    task automatic step(input logic h, input logic v, input logic d, input logic [7:0] rr,
                        input logic [7:0] gg, input logic [7:0] bb, input logic [4:0] ew,
                        input string tag);
        hsync = h;
        vsync = v;
        de    = d;
        r     = rr;
        g     = gg;
        b     = bb;
        @(posedge clk);
        #1;
        n_cmp++;
        assert ({o_hsync, o_vsync, o_de, window} === exp_pipe) else begin
            n_bad++;
            $error("FAIL %s: observed hs/vs/de/win=%b required %b", tag,
                   {o_hsync, o_vsync, o_de, window}, exp_pipe);
        end
        exp_pipe = in_rst ? 8'h00 : {h, v, d, ew};
    endtask

    // Blanking with red on the colour inputs, which must be ignored.
    task automatic blank(input int n, input logic v, input string tag);
        for (int i = 0; i < n; i++) begin
            step((i >= 3 && i < 8), v, 1'b0, 8'hff, 8'h00, 8'h00, 5'b0, tag);
        end
    endtask

    task automatic do_vsync();
        blank(10, 1'b0, "pre_vs");
        blank(8, 1'b1, "vsync");
        blank(10, 1'b0, "post_vs");
    endtask

    // red_x: -1 all red, -2 all black, else single red pixel at that x.
    task automatic line(input int len, input int red_x, input logic [4:0] base, input int sp_x,
                        input logic [4:0] sp_exp, input string tag);
        logic       is_red;
        logic [4:0] ew;
        for (int x = 0; x < len; x++) begin
            is_red = (red_x == -1) || (red_x == x);
            if (x >= 1280)      ew = 5'b0;
            else if (x == sp_x) ew = sp_exp;
            else                ew = base;
            step(1'b0, 1'b0, 1'b1, is_red ? 8'd255 : 8'd0, 8'd0, 8'd0, ew, tag);
        end
        blank(20, 1'b0, tag);
    endtask

    logic [23:0] thr_rgb [8];
    logic        thr_bin [8];
    logic [4:0]  m;

    initial begin
        thr_rgb[0] = {8'd160, 8'd90, 8'd90};  thr_bin[0] = 1'b1;
        thr_rgb[1] = {8'd159, 8'd90, 8'd90};  thr_bin[1] = 1'b0;
        thr_rgb[2] = {8'd160, 8'd91, 8'd90};  thr_bin[2] = 1'b0;
        thr_rgb[3] = {8'd160, 8'd90, 8'd91};  thr_bin[3] = 1'b0;
        thr_rgb[4] = {8'd255, 8'd0, 8'd0};    thr_bin[4] = 1'b1;
        thr_rgb[5] = {8'd0, 8'd0, 8'd0};      thr_bin[5] = 1'b0;
        thr_rgb[6] = {8'd161, 8'd89, 8'd89};  thr_bin[6] = 1'b1;
        thr_rgb[7] = {8'd200, 8'd100, 8'd0};  thr_bin[7] = 1'b0;

        // Reset state
        hsync = 1'b1;
        de    = 1'b1;
        r     = 8'hff;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        assert ({o_hsync, o_vsync, o_de, window} === 8'h00) else begin
            n_bad++;
            $error("FAIL reset: observed %b required %b", {o_hsync, o_vsync, o_de, window},
                   8'h00);
        end
        rstn   = 1'b1;
        in_rst = 1'b0;
        exp_pipe = 8'h00;

        // Threshold edges on window[0]
        do_vsync();
        for (int x = 0; x < 8; x++) begin
            step(1'b0, 1'b0, 1'b1, thr_rgb[x][23:16], thr_rgb[x][15:8], thr_rgb[x][7:0],
                 {4'b0, thr_bin[x]}, "threshold");
        end
        blank(20, 1'b0, "threshold");

        // All-red frame: window fills one line at a time
        do_vsync();
        for (int l = 0; l < 6; l++) begin
            m = 5'((2 << ((l < 4) ? l : 4)) - 1);
            line(1280, -1, m, -1, 5'b0, "red_frame");
        end

        // Black frame with one red pixel at x=7 on line 10; line 0 shows no carry-over
        do_vsync();
        for (int l = 0; l < 15; l++) begin
            m = (l >= 10 && l <= 14) ? 5'(1 << (l - 10)) : 5'b0;
            line(1280, (l == 10) ? 7 : -2, 5'b0, 7, m, (l == 0) ? "black_line0" : "dot");
        end

        // Over-long lines: columns >= 1280 give zero and are not stored
        do_vsync();
        line(1300, -1, 5'b00001, -1, 5'b0, "long_red");
        line(1300, -2, 5'b00010, -1, 5'b0, "long_black");

        // Reset pulsed mid-line
        do_vsync();
        line(1280, -1, 5'b00001, -1, 5'b0, "pre_rst");
        line(1280, -1, 5'b00011, -1, 5'b0, "pre_rst");
        line(1280, -1, 5'b00111, -1, 5'b0, "pre_rst");
        for (int x = 0; x < 100; x++) begin
            step(1'b0, 1'b0, 1'b1, 8'd255, 8'd0, 8'd0, 5'b01111, "pre_rst_part");
        end
        #2;
        rstn   = 1'b0;
        in_rst = 1'b1;
        #1;
        n_cmp++;
        assert ({o_hsync, o_vsync, o_de, window} === 8'h00) else begin
            n_bad++;
            $error("FAIL rst_async: observed %b required %b",
                   {o_hsync, o_vsync, o_de, window}, 8'h00);
        end
        exp_pipe = 8'h00;
        for (int x = 0; x < 50; x++) begin
            step(1'b0, 1'b0, 1'b1, 8'd255, 8'd0, 8'd0, 5'b0, "in_rst");
        end
        blank(5, 1'b0, "in_rst");
        #2;
        rstn   = 1'b1;
        in_rst = 1'b0;
        blank(20, 1'b0, "post_rst");
        line(1280, -1, 5'b00001, -1, 5'b0, "refill");
        line(1280, -1, 5'b00011, -1, 5'b0, "refill");
        do_vsync();
        for (int l = 0; l < 5; l++) begin
            m = 5'((2 << l) - 1);
            line(1280, -1, m, -1, 5'b0, "after_rst_frame");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
